// File: rtl/s2mm_pkg.sv
// Shared definitions for the two-port S2MM receive arbiter.
// Holds the arbiter state encoding, the FIFO word widths and the bit positions
// of the sideband fields inside the good (data) and ctrl (status) FIFO words.
package s2mm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CTRL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Good FIFO word: [72]=eof, [71:64]=byte keep, [63:0]=data
  localparam int GOOD_W       = 73;
  localparam int GOOD_EOF     = 72;
  localparam int GOOD_KEEP_HI = 71;
  localparam int GOOD_KEEP_LO = 64;

  // Ctrl FIFO word: [36]=last, [35:32]=keep, [31:0]=status
  localparam int CTRL_W       = 37;
  localparam int CTRL_LAST    = 36;
  localparam int CTRL_KEEP_HI = 35;
  localparam int CTRL_KEEP_LO = 32;

  localparam int DEF_CTRL_WORDS = 6;

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-stream register slice.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   upstream handshake; s_ready is a flop output
//   s_data            upstream payload
//   m_valid/m_ready   downstream handshake; m_valid is a flop output
//   m_data            downstream payload (registered)
// The skid entry catches the one word that may arrive in the cycle after the
// downstream stalls, so s_ready can be registered without losing throughput.
module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             s_ready_q, s_ready_d;
  logic             acc;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    acc          = s_valid & s_ready_q;
    if (m_ready || !m_valid_q) begin
      // Output register frees up: refill from skid first to keep order.
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        m_valid_d = acc;
        if (acc) m_data_d = s_data;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
    s_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b1;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: rtl/s2mm_rx_arb.sv
// Frame-atomic arbiter sharing one S2MM DMA channel between two RX ports.
// A port requests when its ctrl FIFO is non-empty (a whole frame is buffered).
// Per grant: stream the frame's data beats to RXD, then its status words to
// RXS, spend one DONE cycle on bookkeeping, then re-arbitrate.
// Ports:
//   s2mm_clk, s2mm_reset         clock, synchronous active-high reset
//   pN_good_fifo_*               FWFT data FIFO of port N (rdata/empty/rden)
//   pN_ctrl_fifo_*               FWFT status FIFO of port N (rdata/empty/rden)
//   m_axis_rxd_*                 64-bit data stream to the DMA
//   m_axis_rxs_*                 32-bit status stream to the DMA
//   rx_port_sel                  currently granted port
//   frame_cnt_p0/p1              frames forwarded per port (wrapping)
//   ctrl_err                     sticky status-word count mismatch
//   s2mm_arb_dbg                 {ctrl_err, grant, state[1:0]}
module s2mm_rx_arb
  import s2mm_pkg::*;
#(
  parameter int C_FIXED_PRIO = 0,
  parameter int C_CTRL_WORDS = DEF_CTRL_WORDS
) (
  input  logic              s2mm_clk,
  input  logic              s2mm_reset,
  input  logic [GOOD_W-1:0] p0_good_fifo_rdata,
  input  logic              p0_good_fifo_empty,
  output logic              p0_good_fifo_rden,
  input  logic [CTRL_W-1:0] p0_ctrl_fifo_rdata,
  input  logic              p0_ctrl_fifo_empty,
  output logic              p0_ctrl_fifo_rden,
  input  logic [GOOD_W-1:0] p1_good_fifo_rdata,
  input  logic              p1_good_fifo_empty,
  output logic              p1_good_fifo_rden,
  input  logic [CTRL_W-1:0] p1_ctrl_fifo_rdata,
  input  logic              p1_ctrl_fifo_empty,
  output logic              p1_ctrl_fifo_rden,
  output logic [63:0]       m_axis_rxd_tdata,
  output logic [7:0]        m_axis_rxd_tkeep,
  output logic              m_axis_rxd_tlast,
  output logic              m_axis_rxd_tvalid,
  input  logic              m_axis_rxd_tready,
  output logic [31:0]       m_axis_rxs_tdata,
  output logic [3:0]        m_axis_rxs_tkeep,
  output logic              m_axis_rxs_tlast,
  output logic              m_axis_rxs_tvalid,
  input  logic              m_axis_rxs_tready,
  output logic              rx_port_sel,
  output logic [31:0]       frame_cnt_p0,
  output logic [31:0]       frame_cnt_p1,
  output logic              ctrl_err,
  output logic [3:0]        s2mm_arb_dbg
);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [31:0] frame_cnt_p0_q, frame_cnt_p0_d;
  logic [31:0] frame_cnt_p1_q, frame_cnt_p1_d;
  logic        ctrl_err_q, ctrl_err_d;

  logic              req0, req1;
  logic              g_empty, c_empty;
  logic [GOOD_W-1:0] g_rdata, rxd_m_data;
  logic [CTRL_W-1:0] c_rdata, rxs_m_data;
  logic              good_rden, ctrl_rden;
  logic              rxd_s_ready, rxs_s_ready;
  logic [4:0]        word_inc;

  assign req0    = !p0_ctrl_fifo_empty;
  assign req1    = !p1_ctrl_fifo_empty;
  assign g_empty = grant_q ? p1_good_fifo_empty : p0_good_fifo_empty;
  assign g_rdata = grant_q ? p1_good_fifo_rdata : p0_good_fifo_rdata;
  assign c_empty = grant_q ? p1_ctrl_fifo_empty : p0_ctrl_fifo_empty;
  assign c_rdata = grant_q ? p1_ctrl_fifo_rdata : p0_ctrl_fifo_rdata;
  // One bit wider so a saturated count still compares correctly.
  assign word_inc = {1'b0, word_cnt_q} + 5'd1;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    word_cnt_d     = word_cnt_q;
    frame_cnt_p0_d = frame_cnt_p0_q;
    frame_cnt_p1_d = frame_cnt_p1_q;
    ctrl_err_d     = ctrl_err_q;
    good_rden      = 1'b0;
    ctrl_rden      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) grant_d = (C_FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
          else              grant_d = req1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        good_rden = !g_empty && rxd_s_ready;
        if (good_rden && g_rdata[GOOD_EOF]) state_d = S_CTRL;
      end
      S_CTRL: begin
        ctrl_rden = !c_empty && rxs_s_ready;
        if (ctrl_rden) begin
          if (word_cnt_q != 4'hF) word_cnt_d = word_cnt_q + 4'd1;
          if (c_rdata[CTRL_LAST]) begin
            state_d = S_DONE;
            if (word_inc != 5'(C_CTRL_WORDS)) ctrl_err_d = 1'b1;
          end else if (word_inc >= 5'd15) begin
            // Runaway status list: flag it but keep draining until last.
            ctrl_err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        if (grant_q) frame_cnt_p1_d = frame_cnt_p1_q + 32'd1;
        else         frame_cnt_p0_d = frame_cnt_p0_q + 32'd1;
        word_cnt_d = 4'd0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s2mm_clk) begin
    if (s2mm_reset) begin
      state_q        <= S_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      word_cnt_q     <= 4'd0;
      frame_cnt_p0_q <= 32'd0;
      frame_cnt_p1_q <= 32'd0;
      ctrl_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      word_cnt_q     <= word_cnt_d;
      frame_cnt_p0_q <= frame_cnt_p0_d;
      frame_cnt_p1_q <= frame_cnt_p1_d;
      ctrl_err_q     <= ctrl_err_d;
    end
  end

  assign p0_good_fifo_rden = good_rden & ~grant_q;
  assign p1_good_fifo_rden = good_rden &  grant_q;
  assign p0_ctrl_fifo_rden = ctrl_rden & ~grant_q;
  assign p1_ctrl_fifo_rden = ctrl_rden &  grant_q;

  // The FIFO word layout is kept as-is through the slice and split at the edge.
  axis_skid_slice #(.WIDTH(GOOD_W)) u_rxd_slice (
    .clk     (s2mm_clk),
    .rst     (s2mm_reset),
    .s_valid (good_rden),
    .s_ready (rxd_s_ready),
    .s_data  (g_rdata),
    .m_valid (m_axis_rxd_tvalid),
    .m_ready (m_axis_rxd_tready),
    .m_data  (rxd_m_data)
  );

  axis_skid_slice #(.WIDTH(CTRL_W)) u_rxs_slice (
    .clk     (s2mm_clk),
    .rst     (s2mm_reset),
    .s_valid (ctrl_rden),
    .s_ready (rxs_s_ready),
    .s_data  (c_rdata),
    .m_valid (m_axis_rxs_tvalid),
    .m_ready (m_axis_rxs_tready),
    .m_data  (rxs_m_data)
  );

  assign m_axis_rxd_tdata = rxd_m_data[63:0];
  assign m_axis_rxd_tkeep = rxd_m_data[GOOD_KEEP_HI:GOOD_KEEP_LO];
  assign m_axis_rxd_tlast = rxd_m_data[GOOD_EOF];
  assign m_axis_rxs_tdata = rxs_m_data[31:0];
  assign m_axis_rxs_tkeep = rxs_m_data[CTRL_KEEP_HI:CTRL_KEEP_LO];
  assign m_axis_rxs_tlast = rxs_m_data[CTRL_LAST];

  assign rx_port_sel  = grant_q;
  assign frame_cnt_p0 = frame_cnt_p0_q;
  assign frame_cnt_p1 = frame_cnt_p1_q;
  assign ctrl_err     = ctrl_err_q;
  assign s2mm_arb_dbg = {ctrl_err_q, grant_q, state_q};

endmodule

// File: tb/tb_s2mm_rx_arb.sv
// Bench for s2mm_rx_arb. Two DUTs run side by side on identical FIFO
// contents: index 0 is round-robin, index 1 is fixed priority. Frames are
// loaded in batches while the DUTs are idle; a reference model orders each
// batch by the arbitration policy and queues the expected beats/words, and a
// monitor pops and compares whenever a stream handshake happens.
module tb_s2mm_rx_arb;

  typedef struct {
    int         port;
    int         nbeats;
    int         nwords;
    logic [7:0] keep;
    int         tag;
  } fr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [72:0] g_rdata [2][2];
  logic        g_empty [2][2];
  logic        g_rden  [2][2];
  logic [36:0] c_rdata [2][2];
  logic        c_empty [2][2];
  logic        c_rden  [2][2];
  logic [63:0] rxd_tdata [2];
  logic [7:0]  rxd_tkeep [2];
  logic        rxd_tlast [2];
  logic        rxd_tvalid[2];
  logic [31:0] rxs_tdata [2];
  logic [3:0]  rxs_tkeep [2];
  logic        rxs_tlast [2];
  logic        rxs_tvalid[2];
  logic        rxd_tready, rxs_tready;
  logic        port_sel[2];
  logic [31:0] fcnt0[2], fcnt1[2];
  logic        cerr[2];
  logic [3:0]  dbg[2];

  s2mm_rx_arb #(.C_FIXED_PRIO(0), .C_CTRL_WORDS(6)) dut_rr (
    .s2mm_clk(clk), .s2mm_reset(rst),
    .p0_good_fifo_rdata(g_rdata[0][0]), .p0_good_fifo_empty(g_empty[0][0]), .p0_good_fifo_rden(g_rden[0][0]),
    .p0_ctrl_fifo_rdata(c_rdata[0][0]), .p0_ctrl_fifo_empty(c_empty[0][0]), .p0_ctrl_fifo_rden(c_rden[0][0]),
    .p1_good_fifo_rdata(g_rdata[0][1]), .p1_good_fifo_empty(g_empty[0][1]), .p1_good_fifo_rden(g_rden[0][1]),
    .p1_ctrl_fifo_rdata(c_rdata[0][1]), .p1_ctrl_fifo_empty(c_empty[0][1]), .p1_ctrl_fifo_rden(c_rden[0][1]),
    .m_axis_rxd_tdata(rxd_tdata[0]), .m_axis_rxd_tkeep(rxd_tkeep[0]), .m_axis_rxd_tlast(rxd_tlast[0]),
    .m_axis_rxd_tvalid(rxd_tvalid[0]), .m_axis_rxd_tready(rxd_tready),
    .m_axis_rxs_tdata(rxs_tdata[0]), .m_axis_rxs_tkeep(rxs_tkeep[0]), .m_axis_rxs_tlast(rxs_tlast[0]),
    .m_axis_rxs_tvalid(rxs_tvalid[0]), .m_axis_rxs_tready(rxs_tready),
    .rx_port_sel(port_sel[0]), .frame_cnt_p0(fcnt0[0]), .frame_cnt_p1(fcnt1[0]),
    .ctrl_err(cerr[0]), .s2mm_arb_dbg(dbg[0])
  );

  s2mm_rx_arb #(.C_FIXED_PRIO(1), .C_CTRL_WORDS(6)) dut_fp (
    .s2mm_clk(clk), .s2mm_reset(rst),
    .p0_good_fifo_rdata(g_rdata[1][0]), .p0_good_fifo_empty(g_empty[1][0]), .p0_good_fifo_rden(g_rden[1][0]),
    .p0_ctrl_fifo_rdata(c_rdata[1][0]), .p0_ctrl_fifo_empty(c_empty[1][0]), .p0_ctrl_fifo_rden(c_rden[1][0]),
    .p1_good_fifo_rdata(g_rdata[1][1]), .p1_good_fifo_empty(g_empty[1][1]), .p1_good_fifo_rden(g_rden[1][1]),
    .p1_ctrl_fifo_rdata(c_rdata[1][1]), .p1_ctrl_fifo_empty(c_empty[1][1]), .p1_ctrl_fifo_rden(c_rden[1][1]),
    .m_axis_rxd_tdata(rxd_tdata[1]), .m_axis_rxd_tkeep(rxd_tkeep[1]), .m_axis_rxd_tlast(rxd_tlast[1]),
    .m_axis_rxd_tvalid(rxd_tvalid[1]), .m_axis_rxd_tready(rxd_tready),
    .m_axis_rxs_tdata(rxs_tdata[1]), .m_axis_rxs_tkeep(rxs_tkeep[1]), .m_axis_rxs_tlast(rxs_tlast[1]),
    .m_axis_rxs_tvalid(rxs_tvalid[1]), .m_axis_rxs_tready(rxs_tready),
    .rx_port_sel(port_sel[1]), .frame_cnt_p0(fcnt0[1]), .frame_cnt_p1(fcnt1[1]),
    .ctrl_err(cerr[1]), .s2mm_arb_dbg(dbg[1])
  );

  // FWFT FIFO models, one set per DUT
  logic [72:0] gmem[2][2][256];
  logic [36:0] cmem[2][2][256];
  logic [7:0]  gwr[2][2], grd[2][2], cwr[2][2], crd[2][2];
  bit          pg[2][2], pc[2][2];

  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        g_empty[d][p] = (gwr[d][p] == grd[d][p]);
        c_empty[d][p] = (cwr[d][p] == crd[d][p]);
        g_rdata[d][p] = gmem[d][p][grd[d][p]];
        c_rdata[d][p] = cmem[d][p][crd[d][p]];
      end
  end

  int n_cmp = 0, n_bad = 0, n_seen0 = 0, mode = 0;
  bit tog;
  logic [72:0] exp_rxd0[$], exp_rxd1[$];
  logic [36:0] exp_rxs0[$], exp_rxs1[$];
  int m_last[2];
  int m_cnt[2][2];
  bit m_err[2];
  int next_tag = 1;
  fr_t batch[$];

  task automatic chk(string nm, logic [72:0] act, logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(string nm, logic [72:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h expected none (t=%0t)", nm, act, $time);
  endtask

  function automatic logic [72:0] mk_beat(fr_t f, int i);
    bit last;
    logic [63:0] dat;
    last = (i == f.nbeats - 1);
    dat  = {16'(f.tag), 16'(i), (32'(f.tag) * 32'h9E3779B1) ^ 32'(i)};
    return {last, last ? f.keep : 8'hFF, dat};
  endfunction

  function automatic logic [36:0] mk_word(fr_t f, int i);
    bit last;
    last = (i == f.nwords - 1);
    return {last, last ? 4'(f.tag | 1) : 4'hF, 16'(f.tag), 16'(i) ^ 16'h5A5A};
  endfunction

  // Pops happen on the posedge where rden is high; decide at the negedge
  // (rden is stable there) and move the read pointers at the edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          pg[d][p] = 1'b0;
          pc[d][p] = 1'b0;
          if (!rst) begin
            if (g_rden[d][p]) begin
              chk("grant_port_on_pop", 73'(port_sel[d]), 73'(p));
              if (g_empty[d][p]) fail("good_pop_empty", 73'(p));
              else pg[d][p] = 1'b1;
            end
            if (c_rden[d][p]) begin
              if (c_empty[d][p]) fail("ctrl_pop_empty", 73'(p));
              else pc[d][p] = 1'b1;
            end
          end
        end
      @(posedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          if (rst) begin
            grd[d][p] <= gwr[d][p];
            crd[d][p] <= cwr[d][p];
          end else begin
            if (pg[d][p]) grd[d][p] <= grd[d][p] + 8'd1;
            if (pc[d][p]) crd[d][p] <= crd[d][p] + 8'd1;
          end
        end
    end
  end

  // Sink: pick tready for the coming edge, then score any handshake it makes.
  initial begin
    logic [72:0] got, e;
    logic [36:0] gw, ew;
    bit ok;
    rxd_tready = 1'b1;
    rxs_tready = 1'b1;
    tog = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin tog = ~tog; rxd_tready = tog; rxs_tready = 1'b1; end
        2: begin rxd_tready = 1'($urandom_range(0, 1)); rxs_tready = 1'($urandom_range(0, 1)); end
        default: begin rxd_tready = 1'b1; rxs_tready = 1'b1; end
      endcase
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (rxd_tvalid[d] && rxd_tready) begin
            got = {rxd_tlast[d], rxd_tkeep[d], rxd_tdata[d]};
            ok = 1'b0;
            e  = '0;
            if (d == 0) begin
              n_seen0++;
              if (exp_rxd0.size() > 0) begin ok = 1'b1; e = exp_rxd0.pop_front(); end
            end else if (exp_rxd1.size() > 0) begin ok = 1'b1; e = exp_rxd1.pop_front(); end
            if (ok) chk(d == 0 ? "rxd_beat_rr" : "rxd_beat_fp", got, e);
            else    fail("rxd_extra_beat", got);
          end
          if (rxs_tvalid[d] && rxs_tready) begin
            gw = {rxs_tlast[d], rxs_tkeep[d], rxs_tdata[d]};
            ok = 1'b0;
            ew = '0;
            if (d == 0) begin
              if (exp_rxs0.size() > 0) begin ok = 1'b1; ew = exp_rxs0.pop_front(); end
            end else if (exp_rxs1.size() > 0) begin ok = 1'b1; ew = exp_rxs1.pop_front(); end
            if (ok) chk(d == 0 ? "rxs_word_rr" : "rxs_word_fp", 73'(gw), 73'(ew));
            else    fail("rxs_extra_word", 73'(gw));
          end
        end
      end
    end
  end

  task automatic add(int port, int nbeats, int nwords, logic [7:0] keep);
    fr_t f;
    f.port = port; f.nbeats = nbeats; f.nwords = nwords; f.keep = keep; f.tag = next_tag++;
    batch.push_back(f);
  endtask

  // Load the batch into both DUTs' FIFOs at once, then let the model decide
  // the frame order each policy must produce and queue the expected output.
  task automatic issue();
    int q0[$], q1[$];
    int pick, idx;
    @(posedge clk); #2;
    foreach (batch[k]) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < batch[k].nbeats; i++) begin
          gmem[d][batch[k].port][gwr[d][batch[k].port]] = mk_beat(batch[k], i);
          gwr[d][batch[k].port] = gwr[d][batch[k].port] + 8'd1;
        end
        for (int i = 0; i < batch[k].nwords; i++) begin
          cmem[d][batch[k].port][cwr[d][batch[k].port]] = mk_word(batch[k], i);
          cwr[d][batch[k].port] = cwr[d][batch[k].port] + 8'd1;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      q0.delete(); q1.delete();
      foreach (batch[k]) if (batch[k].port == 0) q0.push_back(k); else q1.push_back(k);
      while (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() > 0 && q1.size() > 0) pick = (d == 1) ? 0 : 1 - m_last[d];
        else                                 pick = (q0.size() > 0) ? 0 : 1;
        idx = (pick == 0) ? q0.pop_front() : q1.pop_front();
        for (int i = 0; i < batch[idx].nbeats; i++)
          if (d == 0) exp_rxd0.push_back(mk_beat(batch[idx], i)); else exp_rxd1.push_back(mk_beat(batch[idx], i));
        for (int i = 0; i < batch[idx].nwords; i++)
          if (d == 0) exp_rxs0.push_back(mk_word(batch[idx], i)); else exp_rxs1.push_back(mk_word(batch[idx], i));
        m_last[d] = pick;
        m_cnt[d][pick]++;
        if (batch[idx].nwords != 6) m_err[d] = 1'b1;
      end
    end
    batch.delete();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (dbg[0][1:0] == 2'd0) && (dbg[1][1:0] == 2'd0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) r = r && c_empty[d][p] && g_empty[d][p];
    return r;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    @(posedge clk); #1;
    while (t < 4000 && !(exp_rxd0.size() == 0 && exp_rxd1.size() == 0 &&
                         exp_rxs0.size() == 0 && exp_rxs1.size() == 0 && all_idle())) begin
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk); #1;
    if (t >= 4000) fail("drain_timeout", 73'(t));
    for (int d = 0; d < 2; d++) begin
      chk("frame_cnt_p0", 73'(fcnt0[d]), 73'(m_cnt[d][0]));
      chk("frame_cnt_p1", 73'(fcnt1[d]), 73'(m_cnt[d][1]));
      chk("ctrl_err", 73'(cerr[d]), 73'(m_err[d]));
      chk("dbg_err_bit", 73'(dbg[d][3]), 73'(m_err[d]));
      chk("rxd_tvalid_idle", 73'(rxd_tvalid[d]), 73'(0));
      chk("rxs_tvalid_idle", 73'(rxs_tvalid[d]), 73'(0));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rxd_tvalid", 73'(rxd_tvalid[d]), 73'(0));
      chk("rst_rxs_tvalid", 73'(rxs_tvalid[d]), 73'(0));
      chk("rst_state", 73'(dbg[d][1:0]), 73'(0));
      chk("rst_grant", 73'(port_sel[d]), 73'(0));
      chk("rst_cnt_p0", 73'(fcnt0[d]), 73'(0));
      chk("rst_cnt_p1", 73'(fcnt1[d]), 73'(0));
      chk("rst_ctrl_err", 73'(cerr[d]), 73'(0));
      for (int p = 0; p < 2; p++) begin
        chk("rst_good_rden", 73'(g_rden[d][p]), 73'(0));
        chk("rst_ctrl_rden", 73'(c_rden[d][p]), 73'(0));
      end
      m_last[d] = 1;
      m_cnt[d][0] = 0;
      m_cnt[d][1] = 0;
      m_err[d] = 1'b0;
    end
    exp_rxd0.delete(); exp_rxd1.delete();
    exp_rxs0.delete(); exp_rxs1.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, t;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        gwr[d][p] = 8'd0; grd[d][p] = 8'd0; cwr[d][p] = 8'd0; crd[d][p] = 8'd0;
      end
    do_reset();

    // Two frames per port, all present at once: RR p0,p1,p0,p1 vs fixed p0,p0,p1,p1
    add(0, 4, 6, 8'hFF); add(1, 3, 6, 8'h01);
    add(0, 2, 6, 8'h3F); add(1, 5, 6, 8'h7F);
    issue(); drain();

    // Single p0 frame, 3 beats, short keep on the eof beat
    add(0, 3, 6, 8'h0F);
    issue(); drain();

    // 8-beat frame with RXD tready toggling every cycle
    mode = 1;
    add(1, 8, 6, 8'hFF);
    issue(); drain();

    // Random sizes and ports with random backpressure on both streams
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++)
        add(int'($urandom_range(0, 1)), int'($urandom_range(1, 10)), 6, 8'($urandom_range(1, 255)));
      issue(); drain();
    end
    mode = 0;

    // Short status list sets the sticky error; next frame still goes through
    add(1, 3, 4, 8'h03);
    issue(); drain();
    add(0, 2, 6, 8'hFF);
    issue(); drain();

    // Reset while the second data beat is moving
    add(0, 6, 6, 8'hFF);
    issue();
    s0 = n_seen0;
    t = 0;
    while (n_seen0 < s0 + 1 && t < 200) begin @(posedge clk); t++; end
    if (t >= 200) fail("wait_first_beat", 73'(t));
    do_reset();
    add(1, 2, 6, 8'h0F); add(0, 3, 6, 8'hFF);
    issue(); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
